shift_arbiter: RTL and testbench
================================

SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 SHALL have parameter FIRST_PRIO, default 0, meaning the requester favoured by round-robin immediately after reset.
REQ-002 SHALL have one clock and an asynchronous, active-low reset: clock  in  1  rising-edge clock for all state.
REQ-003 SHALL have reset_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have req_valid  in  2  per-requester request valid (bit i = requester i).
REQ-005 SHALL have req_ready  out  2  per-requester request accept.
REQ-006 SHALL have req0_data, req1_data  in  32 each  operands.
REQ-007 SHALL have req0_shamt, req1_shamt  in  5 each  shift amounts.
REQ-008 SHALL have req0_op, req1_op  in  2 each  op codes: 00 SLL, 01 SRL, 10 SRA, 11 pass-through.
REQ-009 SHALL have rsp_valid  out  2  per-requester result valid.
REQ-010 SHALL have rsp_ready  in  2  per-requester result accept.
REQ-011 SHALL have rsp_data  out  32  shared result bus, meaningful only while a rsp_valid bit is high.
REQ-012 SHALL have busy  out  1  high in any state other than IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-014 In IDLE, SHALL drive req_ready combinationally to the one-hot grant: if only one req_valid bit is high, grant it; if both are high, grant the requester not granted last.
REQ-015 SHALL transfer a request on req_valid[i] && req_ready[i], capture data/shamt/op, record grant index g, set last-grant to g, and go to EXEC.
REQ-016 SHALL hold req_ready at 00 in EXEC and RESP.
REQ-017 In EXEC, SHALL drive the captured operands into the shifter, register its output into rsp_data, and go to RESP, taking exactly one cycle.
REQ-018 In RESP, SHALL hold rsp_valid[g]=1 with rsp_data stable until rsp_ready[g]=1, then return to IDLE on the next edge.
REQ-019 SHALL ignore rsp_ready[!g], and SHALL have at most one rsp_valid bit high at any time.
REQ-020 Latency: SHALL assert rsp_valid exactly 2 cycles after the accepting edge, and SHALL accept a new request no earlier than the cycle after the response handshake (minimum 3 cycles per operation).
REQ-021 Shift semantics: SLL SHALL zero-fill; SRL SHALL zero-fill; SRA SHALL replicate bit 31; shamt=0 SHALL yield the operand unchanged; op 11 SHALL yield the operand unchanged for any shamt.
REQ-022 SHALL ignore a req_valid deassertion while not ready, without error.
REQ-023 A requester whose valid stays high while the other is served SHALL be granted at the next IDLE, with no starvation.

Reset
REQ-024 SHALL, on reset_n low, immediately force state=IDLE, req_ready=00, rsp_valid=00, rsp_data=0, busy=0, and last-grant such that FIRST_PRIO wins the first tie.
REQ-025 Reset mid-operation SHALL abort the in-flight request silently, with no response issued.
REQ-026 Reset deassertion SHALL take effect on the following clock edge.

Structure
REQ-027 SHALL place the op-code constants (OP_SLL, OP_SRL, OP_SRA, OP_PASS) and the FSM state encodings in the shared package shift_pkg.
REQ-028 SHALL instantiate one sub-module, barrel_shifter (32-bit, 5-stage log shifter with SLL/SRL/SRA), as the shared datapath.
REQ-029 SHALL keep all arbitration logic in shift_arbiter and none in barrel_shifter.

Verification
REQ-030 SHALL cover: req0 SLL 0x0000_0001 shamt 31 -> rsp_valid[0] 2 cycles after accept, rsp_data 0x8000_0000.
REQ-031 SHALL cover: req1 SRA 0x8000_0000 shamt 4 -> rsp_data 0xF800_0000; the same operand with SRL -> 0x0800_0000.
REQ-032 SHALL cover: both req_valid high continuously after reset (FIRST_PRIO=0) -> grants 0,1,0,1 alternate, with req_ready one-hot in IDLE only.
REQ-033 SHALL cover: rsp_ready[g] held low 5 cycles -> rsp_valid and rsp_data stable throughout, and no new accept until 1 cycle after the handshake.
REQ-034 SHALL cover: shamt 0 for every op on 0xDEAD_BEEF, plus op 11 with shamt 7 -> rsp_data 0xDEAD_BEEF in every case.
REQ-035 SHALL cover: reset_n pulsed low during EXEC -> outputs cleared asynchronously, no rsp_valid afterwards, and the next request completes normally.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared constants and types for the shift arbiter: op codes, FSM encoding
// and a bit-reversal helper used by the datapath.
package shift_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] v);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W; i++) begin
            r[i] = v[DATA_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/barrel_shifter.sv
// 32-bit five-stage logarithmic shifter. Left shifts reuse the right-shift
// network by reversing the operand on the way in and the result on the way out.
module barrel_shifter
    import shift_pkg::*;
(
    input  logic [DATA_W-1:0]  data_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  logic [1:0]         op_i,
    output logic [DATA_W-1:0]  result_o
);

    logic [DATA_W-1:0]  stage [0:SHAMT_W];
    logic [DATA_W-1:0]  src;
    logic [SHAMT_W-1:0] amt;
    logic               fill;

    assign src  = (op_i == OP_SLL) ? bit_rev(data_i) : data_i;
    assign amt  = (op_i == OP_PASS) ? '0 : shamt_i;
    assign fill = (op_i == OP_SRA) & data_i[DATA_W-1];

    assign stage[0] = src;

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        localparam int S = 1 << k;
        assign stage[k+1] = amt[k] ? {{S{fill}}, stage[k][DATA_W-1:S]} : stage[k];
    end

    assign result_o = (op_i == OP_SLL) ? bit_rev(stage[SHAMT_W]) : stage[SHAMT_W];

endmodule

// File: rtl/shift_arbiter.sv
// Two-requester round-robin front end sharing one barrel shifter.
// One operation in flight at a time: IDLE (accept) -> EXEC (shift) -> RESP (hold result).
module shift_arbiter
    import shift_pkg::*;
#(
    parameter int FIRST_PRIO = 0
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [DATA_W-1:0]  req0_data,
    input  logic [DATA_W-1:0]  req1_data,
    input  logic [SHAMT_W-1:0] req0_shamt,
    input  logic [SHAMT_W-1:0] req1_shamt,
    input  logic [1:0]         req0_op,
    input  logic [1:0]         req1_op,
    output logic [1:0]         rsp_valid,
    input  logic [1:0]         rsp_ready,
    output logic [DATA_W-1:0]  rsp_data,
    output logic               busy,
    output logic [1:0]         dbg_state_o
);

    // last_q holds the previous grant; resetting it to the other requester
    // makes FIRST_PRIO win the first tie.
    localparam logic LAST_RST = (FIRST_PRIO == 0) ? 1'b1 : 1'b0;

    state_t             state_q;
    logic               active_q;
    logic               last_q;
    logic               grant_q;
    logic [DATA_W-1:0]  data_q;
    logic [SHAMT_W-1:0] shamt_q;
    logic [1:0]         op_q;
    logic [DATA_W-1:0]  rsp_data_q;
    logic [1:0]         rsp_valid_q;

    logic [1:0]         grant;
    logic               accept;
    logic               accept_idx;
    logic [DATA_W-1:0]  shift_res;

    always_comb begin
        grant = 2'b00;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // active_q delays the first accept until one edge after reset release.
    assign req_ready  = (state_q == ST_IDLE && active_q) ? grant : 2'b00;
    assign accept     = |(req_valid & req_ready);
    assign accept_idx = req_ready[1];

    barrel_shifter u_shifter (
        .data_i   (data_q),
        .shamt_i  (shamt_q),
        .op_i     (op_q),
        .result_o (shift_res)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            active_q    <= 1'b0;
            last_q      <= LAST_RST;
            grant_q     <= 1'b0;
            data_q      <= '0;
            shamt_q     <= '0;
            op_q        <= OP_SLL;
            rsp_data_q  <= '0;
            rsp_valid_q <= 2'b00;
        end else begin
            active_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        grant_q <= accept_idx;
                        last_q  <= accept_idx;
                        data_q  <= accept_idx ? req1_data  : req0_data;
                        shamt_q <= accept_idx ? req1_shamt : req0_shamt;
                        op_q    <= accept_idx ? req1_op    : req0_op;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_data_q  <= shift_res;
                    rsp_valid_q <= grant_q ? 2'b10 : 2'b01;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready[grant_q]) begin
                        rsp_valid_q <= 2'b00;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 2'b00;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign busy        = (state_q != ST_IDLE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: latency, shift semantics, round-robin,
// response back-pressure and mid-operation reset.
module tb_shift_arbiter;

    logic        clock;
    logic        reset_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req0_data, req1_data;
    logic [4:0]  req0_shamt, req1_shamt;
    logic [1:0]  req0_op, req1_op;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_data;
    logic        busy;
    logic [1:0]  dbg_state_o;

    int n_cmp = 0;
    int n_err = 0;

    shift_arbiter #(.FIRST_PRIO(0)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req0_data   (req0_data),
        .req1_data   (req1_data),
        .req0_shamt  (req0_shamt),
        .req1_shamt  (req1_shamt),
        .req0_op     (req0_op),
        .req1_op     (req1_op),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .busy        (busy),
        .dbg_state_o (dbg_state_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic apply_reset();
        reset_n   = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
    endtask

    // Drive one request and wait (bounded) for it to be accepted.
    // Returns 1 time unit after the accepting edge.
    task automatic send(input int idx, input logic [31:0] d, input logic [4:0] sh,
                        input logic [1:0] op, output bit ok);
        if (idx == 0) begin
            req0_data = d; req0_shamt = sh; req0_op = op;
        end else begin
            req1_data = d; req1_shamt = sh; req1_op = op;
        end
        req_valid[idx] = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (req_ready[idx]) begin
                ok = 1'b1;
                break;
            end
            @(posedge clock);
            #1;
        end
        if (ok) begin
            @(posedge clock);
            #1;
        end
        req_valid[idx] = 1'b0;
    endtask

    // Full operation with immediate response acceptance.
    task automatic run_op(input int idx, input logic [31:0] d, input logic [4:0] sh,
                          input logic [1:0] op, output logic [1:0] v1,
                          output logic [1:0] v2, output logic [31:0] got,
                          output logic b1);
        bit ok;
        send(idx, d, sh, op, ok);
        if (!ok) begin
            v1 = 'x; v2 = 'x; got = 'x; b1 = 'x;
            return;
        end
        v1 = rsp_valid;
        b1 = busy;
        @(posedge clock);
        #1;
        v2  = rsp_valid;
        got = rsp_data;
        rsp_ready[idx] = 1'b1;
        @(posedge clock);
        #1;
        rsp_ready = 2'b00;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        req_valid = 2'b11;
        rsp_ready = 2'b00;
        req0_data = '0; req1_data = '0; req0_shamt = '0; req1_shamt = '0;
        req0_op = 2'b11; req1_op = 2'b11;
        #3;
        n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
        n_cmp++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL reset_rsp_valid: got %b expected 00", rsp_valid); end
        n_cmp++; if (rsp_data !== 32'h0) begin n_err++; $display("FAIL reset_rsp_data: got %h expected 0", rsp_data); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (dbg_state_o !== 2'b00) begin n_err++; $display("FAIL reset_state: got %b expected 00", dbg_state_o); end
        repeat (2) @(posedge clock);
        #1;
        req_valid = 2'b01;
        reset_n   = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL release_no_ready: got %b expected 00", req_ready); end
        @(posedge clock);
        #1;
        n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL release_ready: got %b expected 01", req_ready); end
        req_valid = 2'b00;
        @(posedge clock);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL release_idle: got busy %b expected 0", busy); end
    endtask

    task automatic test_sll();
        logic [1:0] v1, v2; logic [31:0] got; logic b1;
        run_op(0, 32'h0000_0001, 5'd31, 2'b00, v1, v2, got, b1);
        n_cmp++; if (v1 !== 2'b00) begin n_err++; $display("FAIL sll_early_valid: got %b expected 00", v1); end
        n_cmp++; if (b1 !== 1'b1) begin n_err++; $display("FAIL sll_busy: got %b expected 1", b1); end
        n_cmp++; if (v2 !== 2'b01) begin n_err++; $display("FAIL sll_valid: got %b expected 01", v2); end
        n_cmp++; if (got !== 32'h8000_0000) begin n_err++; $display("FAIL sll_data: got %h expected 80000000", got); end
    endtask

    task automatic test_sra_srl();
        logic [1:0] v1, v2; logic [31:0] got; logic b1;
        run_op(1, 32'h8000_0000, 5'd4, 2'b10, v1, v2, got, b1);
        n_cmp++; if (v2 !== 2'b10) begin n_err++; $display("FAIL sra_valid: got %b expected 10", v2); end
        n_cmp++; if (got !== 32'hF800_0000) begin n_err++; $display("FAIL sra_data: got %h expected f8000000", got); end
        run_op(1, 32'h8000_0000, 5'd4, 2'b01, v1, v2, got, b1);
        n_cmp++; if (got !== 32'h0800_0000) begin n_err++; $display("FAIL srl_data: got %h expected 08000000", got); end
        run_op(0, 32'h7000_0000, 5'd4, 2'b10, v1, v2, got, b1);
        n_cmp++; if (got !== 32'h0700_0000) begin n_err++; $display("FAIL sra_pos_data: got %h expected 07000000", got); end
    endtask

    task automatic test_alternate();
        logic [1:0]  exp_g [4];
        logic [31:0] exp_d;
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
        apply_reset();
        req0_data = 32'h1111_0000; req0_shamt = 5'd3; req0_op = 2'b11;
        req1_data = 32'h0000_2222; req1_shamt = 5'd1; req1_op = 2'b01;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        @(posedge clock);
        #1;
        for (int i = 0; i < 4; i++) begin
            exp_d = exp_g[i][0] ? 32'h1111_0000 : 32'h0000_1111;
            n_cmp++; if (req_ready !== exp_g[i]) begin n_err++; $display("FAIL alt_grant[%0d]: got %b expected %b", i, req_ready, exp_g[i]); end
            @(posedge clock);
            #1;
            n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL alt_exec_ready[%0d]: got %b expected 00", i, req_ready); end
            @(posedge clock);
            #1;
            n_cmp++; if (rsp_valid !== exp_g[i] || rsp_data !== exp_d || req_ready !== 2'b00) begin
                n_err++;
                $display("FAIL alt_resp[%0d]: got valid %b data %h ready %b expected valid %b data %h ready 00",
                         i, rsp_valid, rsp_data, req_ready, exp_g[i], exp_d);
            end
            @(posedge clock);
            #1;
        end
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        @(posedge clock);
        #1;
    endtask

    task automatic test_backpressure();
        bit ok;
        int bad;
        send(0, 32'h1234_5678, 5'd4, 2'b01, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL bp_accept: got no accept expected accept"); end
        @(posedge clock);
        #1;
        req1_data = 32'hCAFE_F00D; req1_shamt = 5'd9; req1_op = 2'b11;
        req_valid = 2'b10;
        rsp_ready = 2'b10;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid !== 2'b01 || rsp_data !== 32'h0123_4567 || req_ready !== 2'b00) begin
                bad++;
                $display("FAIL bp_hold[%0d]: got valid %b data %h ready %b expected valid 01 data 01234567 ready 00",
                         i, rsp_valid, rsp_data, req_ready);
            end
            @(posedge clock);
            #1;
        end
        n_cmp++; if (bad != 0) n_err++;
        rsp_ready = 2'b01;
        @(posedge clock);
        #1;
        rsp_ready = 2'b00;
        n_cmp++; if (rsp_valid !== 2'b00 || busy !== 1'b0) begin n_err++; $display("FAIL bp_release: got valid %b busy %b expected 00 0", rsp_valid, busy); end
        n_cmp++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL bp_waiting_grant: got %b expected 10", req_ready); end
        @(posedge clock);
        #1;
        req_valid = 2'b00;
        @(posedge clock);
        #1;
        n_cmp++; if (rsp_valid !== 2'b10 || rsp_data !== 32'hCAFE_F00D) begin n_err++; $display("FAIL bp_second: got valid %b data %h expected 10 cafef00d", rsp_valid, rsp_data); end
        rsp_ready = 2'b10;
        @(posedge clock);
        #1;
        rsp_ready = 2'b00;
    endtask

    task automatic test_shamt_zero();
        logic [1:0] v1, v2; logic [31:0] got; logic b1;
        for (int op = 0; op < 4; op++) begin
            run_op(op % 2, 32'hDEAD_BEEF, 5'd0, 2'(op), v1, v2, got, b1);
            n_cmp++; if (got !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL zero_shamt_op%0d: got %h expected deadbeef", op, got); end
        end
        run_op(1, 32'hDEAD_BEEF, 5'd7, 2'b11, v1, v2, got, b1);
        n_cmp++; if (got !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL pass_shamt7: got %h expected deadbeef", got); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int seen;
        logic [1:0] v1, v2; logic [31:0] got; logic b1;
        send(0, 32'h0000_00FF, 5'd8, 2'b00, ok);
        n_cmp++; if (!ok || busy !== 1'b1) begin n_err++; $display("FAIL mid_exec: got accept %0d busy %b expected 1 1", ok, busy); end
        reset_n = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0 || rsp_valid !== 2'b00 || rsp_data !== 32'h0 || req_ready !== 2'b00) begin
            n_err++;
            $display("FAIL mid_async_clear: got busy %b valid %b data %h ready %b expected 0 00 0 00",
                     busy, rsp_valid, rsp_data, req_ready);
        end
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock);
            #1;
            if (rsp_valid !== 2'b00) seen++;
        end
        n_cmp++; if (seen != 0) begin n_err++; $display("FAIL mid_no_rsp: got %0d cycles of rsp_valid expected 0", seen); end
        run_op(1, 32'h0000_000F, 5'd4, 2'b00, v1, v2, got, b1);
        n_cmp++; if (v2 !== 2'b10 || got !== 32'h0000_00F0) begin n_err++; $display("FAIL mid_next_op: got valid %b data %h expected 10 000000f0", v2, got); end
    endtask

    initial begin
        test_reset();
        test_sll();
        test_sra_srl();
        test_alternate();
        test_backpressure();
        test_shamt_zero();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
